dijkstra_mem_bridge: RTL

// Sits directly downstream of the Dijkstra core's memory port. Converts the core's 16-bit

---
 rtl/dijkstra_pkg.sv | 34 +++
 rtl/dijkstra_mem_bridge_if.sv | 51 +++++
 rtl/dijkstra_word_buffer.sv | 61 ++++++
 rtl/dijkstra_mem_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra memory bridge.
package dijkstra_pkg;

  localparam int BUS_W  = 32;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4,
    ST_HOLD    = 3'd5
  } bridge_state_e;

  // Returned on a read that the bus never answered.
  localparam logic [HALF_W-1:0] MEM_INF = 16'hFFFF;

  localparam logic [3:0] BE_LANE0 = 4'b0011;
  localparam logic [3:0] BE_LANE1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Pick the halfword of a bus word addressed by byte-address bit 1.
  function automatic logic [HALF_W-1:0] lane_sel(input logic [BUS_W-1:0] word,
                                                  input logic lane);
    return lane ? word[BUS_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

  // Byte enables for a halfword write in the given lane.
  function automatic logic [3:0] lane_be(input logic lane);
    return lane ? BE_LANE1 : BE_LANE0;
  endfunction

endpackage

// File: rtl/dijkstra_mem_bridge_if.sv
// Bus bundles for the bridge: core-side halfword port and Avalon-MM master port.

// Core side. The core is the master: it raises an enable and holds it until
// the matching ready pulse.
interface dijkstra_core_if #(
  parameter int AW = 32,
  parameter int DW = 16
);
  logic          core_read_enable;
  logic          core_write_enable;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_write_data;
  logic [DW-1:0] core_read_data;
  logic          core_read_ready;
  logic          core_write_ready;

  modport master (
    output core_read_enable, core_write_enable, core_addr, core_write_data,
    input  core_read_data, core_read_ready, core_write_ready
  );

  modport slave (
    input  core_read_enable, core_write_enable, core_addr, core_write_data,
    output core_read_data, core_read_ready, core_write_ready
  );
endinterface

// Avalon-MM side. The bridge is the master; the memory is the slave.
interface dijkstra_avm_if #(
  parameter int AW = 32,
  parameter int BW = 32
);
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [3:0]    avm_byteenable;
  logic [BW-1:0] avm_writedata;
  logic [BW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/dijkstra_word_buffer.sv
// One-word read buffer: tag, 32-bit word and valid bit, with lookup,
// full-word load, halfword write-through and flush.
module dijkstra_word_buffer #(
  parameter int TAG_W  = 30,
  parameter int WORD_W = 32,
  parameter int HALF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [WORD_W-1:0] word_o,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  load_tag_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic              wr_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_lane_i,
  input  logic [HALF_W-1:0] wr_half_i
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] word_q;
  logic              wr_match;

  // A flush in the same cycle as a lookup forces a miss.
  assign hit_o    = valid_q && (tag_q == lookup_tag_i) && !flush_i;
  assign word_o   = word_q;
  assign wr_match = wr_i && valid_q && (tag_q == wr_tag_i);

  // Valid bit: a load always wins over a coincident flush so the fill completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end
  end

  // Tag and word storage: full load on fill, single-lane update on write-through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q  <= '0;
      word_q <= '0;
    end else if (load_i) begin
      tag_q  <= load_tag_i;
      word_q <= load_word_i;
    end else if (wr_match) begin
      if (wr_lane_i) begin
        word_q[WORD_W-1:HALF_W] <= wr_half_i;
      end else begin
        word_q[HALF_W-1:0] <= wr_half_i;
      end
    end
  end

endmodule

// File: rtl/dijkstra_mem_bridge.sv
// Bridge from the Dijkstra core's 16-bit halfword port to a 32-bit Avalon-MM
// master, with a one-word read buffer and a read timeout that returns MEM_INF.
//
// Handshake: the core raises read or write enable with address/data and holds
// them steady; the request is accepted only in IDLE. Completion is a single-cycle
// core_*_ready pulse (read data valid in the same cycle), followed by one HOLD
// cycle in which the enables are ignored so the core can drop them. On the
// Avalon side a command is held until a cycle with avm_waitrequest low; read data
// is taken only when avm_readdatavalid is high while waiting for it.
module dijkstra_mem_bridge
  import dijkstra_pkg::*;
#(
  parameter int MADDR_WIDTH    = 32,
  parameter int MDATA_WIDTH    = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  algorithm_clock,
  input  logic                  algorithm_reset_n,
  input  logic                  flush,
  dijkstra_core_if.slave        core,
  dijkstra_avm_if.master        avm,
  output logic                  timeout_err,
  output logic                  protocol_err,
  output logic [15:0]           hit_count,
  output bridge_state_e         state_dbg_o
);

  localparam int TAG_W = MADDR_WIDTH - 2;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  bridge_state_e          state_q, state_d;
  logic [TAG_W-1:0]       tag_q;
  logic                   lane_q;
  logic                   is_wr_q;
  logic [BUS_WIDTH-1:0]   resp_word_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   avm_read_q;
  logic                   avm_write_q;
  logic [3:0]             avm_be_q;
  logic [BUS_WIDTH-1:0]   avm_wdata_q;
  logic [15:0]            hit_count_q;
  logic                   timeout_err_q;
  logic                   protocol_err_q;

  logic                   req_rd;
  logic                   req_wr;
  logic [TAG_W-1:0]       req_tag;
  logic                   in_idle;
  logic                   accept;
  logic                   idle_rd_hit;
  logic                   rd_done;
  logic                   rd_tmo;
  logic                   wr_done;
  logic                   buf_hit;
  logic [BUS_WIDTH-1:0]   buf_word;
  logic                   unused_addr_bit;

  assign req_rd          = core.core_read_enable;
  assign req_wr          = core.core_write_enable;
  assign req_tag         = core.core_addr[MADDR_WIDTH-1:2];
  assign unused_addr_bit = core.core_addr[0];

  assign in_idle     = (state_q == ST_IDLE);
  assign accept      = in_idle && (req_rd || req_wr);
  assign idle_rd_hit = in_idle && !req_wr && req_rd && buf_hit;
  assign rd_done     = (state_q == ST_RD_WAIT) && avm.avm_readdatavalid;
  assign rd_tmo      = (state_q == ST_RD_WAIT) && !avm.avm_readdatavalid &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign wr_done     = (state_q == ST_WR_REQ) && !avm.avm_waitrequest;

  dijkstra_word_buffer #(
    .TAG_W  (TAG_W),
    .WORD_W (BUS_WIDTH),
    .HALF_W (MDATA_WIDTH)
  ) u_buf (
    .clk_i        (algorithm_clock),
    .rst_ni       (algorithm_reset_n),
    .flush_i      (flush),
    .lookup_tag_i (req_tag),
    .hit_o        (buf_hit),
    .word_o       (buf_word),
    .load_i       (rd_done),
    .load_tag_i   (tag_q),
    .load_word_i  (avm.avm_readdata),
    .wr_i         (wr_done),
    .wr_tag_i     (tag_q),
    .wr_lane_i    (lane_q),
    .wr_half_i    (avm_wdata_q[MDATA_WIDTH-1:0])
  );

  // State register.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a write request takes priority over a simultaneous read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_wr) begin
          state_d = ST_WR_REQ;
        end else if (req_rd) begin
          state_d = buf_hit ? ST_RESP : ST_RD_REQ;
        end
      end
      ST_RD_REQ:  if (!avm.avm_waitrequest) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_done || rd_tmo) state_d = ST_RESP;
      ST_WR_REQ:  if (wr_done) state_d = ST_RESP;
      ST_RESP:    state_d = ST_HOLD;
      ST_HOLD:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request capture and registered Avalon command; fields only change on accept.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      tag_q       <= '0;
      lane_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      avm_be_q    <= '0;
      avm_wdata_q <= '0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
    end else begin
      if (accept) begin
        tag_q   <= req_tag;
        lane_q  <= core.core_addr[1];
        is_wr_q <= req_wr;
        if (req_wr) begin
          avm_be_q    <= lane_be(core.core_addr[1]);
          avm_wdata_q <= {core.core_write_data, core.core_write_data};
        end else begin
          avm_be_q    <= BE_WORD;
        end
      end
      avm_read_q  <= (state_d == ST_RD_REQ);
      avm_write_q <= (state_d == ST_WR_REQ);
    end
  end

  // Response word: buffer on a hit, bus data on a fill, MEM_INF on timeout.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      resp_word_q <= '0;
    end else if (idle_rd_hit) begin
      resp_word_q <= buf_word;
    end else if (rd_done) begin
      resp_word_q <= avm.avm_readdata;
    end else if (rd_tmo) begin
      resp_word_q <= {MEM_INF, MEM_INF};
    end
  end

  // Timeout counter: cycles spent in RD_WAIT, cleared everywhere else.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      tmo_q <= '0;
    end else if (state_q != ST_RD_WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Sticky error flags and the saturating hit counter.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      hit_count_q    <= '0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (idle_rd_hit && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
      if (rd_tmo) begin
        timeout_err_q <= 1'b1;
      end
      if (in_idle && req_rd && req_wr) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  // Core-side outputs decoded from the registered state.
  always_comb begin
    core.core_read_ready  = 1'b0;
    core.core_write_ready = 1'b0;
    core.core_read_data   = lane_sel(resp_word_q, lane_q);
    if (state_q == ST_RESP) begin
      core.core_read_ready  = !is_wr_q;
      core.core_write_ready = is_wr_q;
    end
  end

  assign avm.avm_address    = {tag_q, 2'b00};
  assign avm.avm_read       = avm_read_q;
  assign avm.avm_write      = avm_write_q;
  assign avm.avm_byteenable = avm_be_q;
  assign avm.avm_writedata  = avm_wdata_q;

  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;
  assign hit_count    = hit_count_q;
  assign state_dbg_o  = state_q;

endmodule
